pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_channel.sv | 112 +++++++++++
 rtl/pwm_ramp_ctrl.sv | 83 ++++++++
 tb/tb_pwm_ramp_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared channel state type and width helpers for the PWM ramp controller
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_e;

    function automatic int duty_width(input int max_duty);
        return $clog2(max_duty + 1);
    endfunction

    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: target edit, start/stop FSM, soft ramp of applied duty
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int MAX_DUTY     = 100,
    parameter int STEP         = 10,
    parameter int RAMP_PERIODS = 1,
    localparam int DUTY_W      = duty_width(MAX_DUTY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] cnt,
    input  logic              period_end,
    input  logic              inc,
    input  logic              dec,
    input  logic              start_stop,
    output logic              pwm_out,
    output logic              running,
    output logic [DUTY_W-1:0] target
);

    localparam int DX     = DUTY_W + 1;
    localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    localparam logic [DX-1:0]     MAX_X     = DX'(MAX_DUTY);
    localparam logic [DX-1:0]     STEP_X    = DX'(STEP);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);

    ch_state_e         state_q, state_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] cur_q, cur_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic              pwm_q, pwm_d;
    logic              ramp_step;
    logic [DX-1:0]     tgt_x;
    logic [DX-1:0]     tgt_up;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            cur_q    <= '0;
            ramp_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            ramp_q   <= ramp_d;
            pwm_q    <= pwm_d;
        end
    end

    // Target saturates at both ends; the extra bit keeps target+STEP from wrapping.
    always_comb begin
        tgt_x    = {1'b0, target_q};
        tgt_up   = tgt_x + STEP_X;
        target_d = target_q;
        if (inc && !dec) begin
            target_d = (tgt_up > MAX_X) ? DUTY_W'(MAX_DUTY) : tgt_up[DUTY_W-1:0];
        end else if (dec && !inc) begin
            target_d = (tgt_x < STEP_X) ? '0 : DUTY_W'(tgt_x - STEP_X);
        end
    end

    assign ramp_step = period_end && (ramp_q == RAMP_LAST) && (state_q != IDLE);

    always_comb begin
        ramp_d = ramp_q;
        if (state_q == IDLE) begin
            ramp_d = '0;
        end else if (period_end) begin
            ramp_d = ramp_step ? '0 : ramp_q + RAMP_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        unique case (state_q)
            IDLE: begin
                cur_d = '0;
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (ramp_step) begin
                    if (cur_q < target_q)      cur_d = cur_q + DUTY_W'(1);
                    else if (cur_q > target_q) cur_d = cur_q - DUTY_W'(1);
                end
                if (start_stop) state_d = STOPPING;
            end
            STOPPING: begin
                if (ramp_step) begin
                    if (cur_q == '0) state_d = IDLE;
                    else             cur_d = cur_q - DUTY_W'(1);
                end
                // A restart wins over the drop to IDLE and resumes from the present cur.
                if (start_stop) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                cur_d   = '0;
            end
        endcase
    end

    assign pwm_d   = (state_q != IDLE) && (cnt < cur_q);
    assign pwm_out = pwm_q;
    assign running = (state_q != IDLE);
    assign target  = target_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - multi-channel PWM controller with shared period counter and duty display mux
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int MAX_DUTY     = 100,
    parameter int STEP         = 10,
    parameter int PRESC        = 1,
    parameter int RAMP_PERIODS = 1,
    localparam int DUTY_W      = duty_width(MAX_DUTY),
    localparam int SEL_W       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic                swt_increase,
    input  logic                swt_decrease,
    input  logic                swt_start_stop,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] motor_running,
    output logic [DUTY_W-1:0]   disp_duty
);

    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [DUTY_W-1:0]  CNT_LAST   = DUTY_W'(MAX_DUTY - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  cnt_q, cnt_d;
    logic               tick;
    logic               period_end;
    logic [CHANNELS-1:0] sel_hit;
    logic [DUTY_W-1:0]  target [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        period_end = tick && (cnt_q == CNT_LAST);
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        cnt_d      = cnt_q;
        if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DUTY_W'(1);
    end

    // Out-of-range selects match no channel, so their pulses are dropped and the display reads 0.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign sel_hit[i] = (int'(ch_sel) == i);

        pwm_channel #(
            .MAX_DUTY    (MAX_DUTY),
            .STEP        (STEP),
            .RAMP_PERIODS(RAMP_PERIODS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt       (cnt_q),
            .period_end(period_end),
            .inc       (swt_increase & sel_hit[i]),
            .dec       (swt_decrease & sel_hit[i]),
            .start_stop(swt_start_stop & sel_hit[i]),
            .pwm_out   (pwm_out[i]),
            .running   (motor_running[i]),
            .target    (target[i])
        );
    end

    always_comb begin
        disp_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_hit[i]) disp_duty = target[i];
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, inc_a, dec_a, ss_a;
    logic [1:0] sel_a;
    logic [2:0] pwm_a, run_a;
    logic [6:0] disp_a;

    logic       rst_b, inc_b, dec_b, ss_b;
    logic       sel_b;
    logic [1:0] pwm_b, run_b;
    logic [6:0] disp_b;

    int ma, mb;
    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int c0, c1, c2, s1, err;

    pwm_ramp_ctrl #(.CHANNELS(3)) dut_a (
        .clk(clk), .rst(rst_a), .ch_sel(sel_a),
        .swt_increase(inc_a), .swt_decrease(dec_a), .swt_start_stop(ss_a),
        .pwm_out(pwm_a), .motor_running(run_a), .disp_duty(disp_a)
    );

    pwm_ramp_ctrl #(.CHANNELS(2), .PRESC(4), .RAMP_PERIODS(2)) dut_b (
        .clk(clk), .rst(rst_b), .ch_sel(sel_b),
        .swt_increase(inc_b), .swt_decrease(dec_b), .swt_start_stop(ss_b),
        .pwm_out(pwm_b), .motor_running(run_b), .disp_duty(disp_b)
    );

    // Reference position in the PWM period: ma mirrors cnt (PRESC=1), mb mirrors presc*cnt (PRESC=4)
    always @(posedge clk) begin
        if (rst_a) ma <= 0; else ma <= (ma == 99) ? 0 : ma + 1;
        if (rst_b) mb <= 0; else mb <= (mb == 399) ? 0 : mb + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ma(input int v);
        logic found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ma == v) begin found = 1'b1; break; end
        end
        check("wait_ma", 32'(found), 1);
    endtask

    task automatic wait_mb(input int v);
        logic found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (mb == v) begin found = 1'b1; break; end
        end
        check("wait_mb", 32'(found), 1);
    endtask

    task automatic window_a(output int h0, output int h1, output int h2);
        wait_ma(1);
        h0 = int'(pwm_a[0]); h1 = int'(pwm_a[1]); h2 = int'(pwm_a[2]);
        repeat (99) begin
            @(negedge clk);
            h0 += int'(pwm_a[0]); h1 += int'(pwm_a[1]); h2 += int'(pwm_a[2]);
        end
    endtask

    task automatic window_b(output int h0, output int h1);
        wait_mb(1);
        h0 = int'(pwm_b[0]); h1 = int'(pwm_b[1]);
        repeat (399) begin
            @(negedge clk);
            h0 += int'(pwm_b[0]); h1 += int'(pwm_b[1]);
        end
    endtask

    task automatic pulse_a(input logic [1:0] sel, input logic i, input logic d, input logic s);
        @(negedge clk);
        sel_a = sel; inc_a = i; dec_a = d; ss_a = s;
        @(negedge clk);
        inc_a = 1'b0; dec_a = 1'b0; ss_a = 1'b0;
    endtask

    task automatic pulse_b(input logic i, input logic s);
        @(negedge clk);
        sel_b = 1'b0; inc_b = i; dec_b = 1'b0; ss_b = s;
        @(negedge clk);
        inc_b = 1'b0; ss_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; sel_a = 2'd0; inc_a = 1'b0; dec_a = 1'b0; ss_a = 1'b0;
        rst_b = 1'b1; sel_b = 1'b0; inc_b = 1'b0; dec_b = 1'b0; ss_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_pwm", 32'(pwm_a), 0);
        check("rst_running", 32'(run_a), 0);
        check("rst_disp", 32'(disp_a), 0);

        err = 0;
        repeat (500) begin
            @(negedge clk);
            if (pwm_a !== 3'b0 || run_a !== 3'b0 || disp_a !== 7'd0) err++;
        end
        check("idle_500", err, 0);

        for (int k = 1; k <= 12; k++) begin
            pulse_a(2'd0, 1'b1, 1'b0, 1'b0);
            check("inc_sat", 32'(disp_a), (k * 10 > 100) ? 100 : k * 10);
        end
        for (int k = 1; k <= 11; k++) begin
            pulse_a(2'd0, 1'b0, 1'b1, 1'b0);
            check("dec_floor", 32'(disp_a), (100 - k * 10 < 0) ? 0 : 100 - k * 10);
        end
        repeat (5) pulse_a(2'd0, 1'b1, 1'b0, 1'b0);
        check("inc_to_50", 32'(disp_a), 50);
        pulse_a(2'd0, 1'b1, 1'b1, 1'b0);
        check("inc_dec_same", 32'(disp_a), 50);
        repeat (2) pulse_a(2'd0, 1'b0, 1'b1, 1'b0);
        check("target_30", 32'(disp_a), 30);

        wait_ma(50);
        pulse_a(2'd0, 1'b0, 1'b0, 1'b1);
        check("start_running", 32'(run_a), 3'b001);
        s1 = 0;
        for (int k = 1; k <= 32; k++) begin
            window_a(c0, c1, c2);
            s1 += c1;
            check("ramp_up", c0, (k > 30) ? 30 : k);
        end

        wait_ma(50);
        pulse_a(2'd0, 1'b0, 1'b0, 1'b1);
        check("stopping_running", 32'(run_a), 3'b001);
        for (int k = 1; k <= 17; k++) begin
            window_a(c0, c1, c2);
            s1 += c1;
            check("ramp_down", c0, 30 - k);
        end
        wait_ma(50);
        pulse_a(2'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            window_a(c0, c1, c2);
            s1 += c1;
            check("resume_from_12", c0, 12 + k);
        end

        wait_ma(50);
        pulse_a(2'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            window_a(c0, c1, c2);
            s1 += c1;
            check("stop_full", c0, 30 - k);
            if (k == 29) check("run_at_cur0", 32'(run_a), 3'b001);
        end
        check("idle_after_stop", 32'(run_a), 0);
        check("ch1_low", s1, 0);

        repeat (7) pulse_a(2'd0, 1'b1, 1'b0, 1'b0);
        check("target_100", 32'(disp_a), 100);
        pulse_a(2'd0, 1'b0, 1'b0, 1'b1);
        pulse_a(2'd1, 1'b0, 1'b0, 1'b1);
        check("both_running", 32'(run_a), 3'b011);
        repeat (100) window_a(c0, c1, c2);
        for (int k = 0; k < 2; k++) begin
            window_a(c0, c1, c2);
            check("full_high", c0, 100);
            check("zero_low", c1, 0);
        end

        pulse_a(2'd3, 1'b1, 1'b0, 1'b0);
        check("bad_sel_disp", 32'(disp_a), 0);
        pulse_a(2'd3, 1'b0, 1'b0, 1'b1);
        check("bad_sel_running", 32'(run_a), 3'b011);
        pulse_a(2'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk); sel_a = 2'd0;
        @(negedge clk);
        check("bad_sel_ch0_target", 32'(disp_a), 100);
        sel_a = 2'd2;
        @(negedge clk);
        check("ch2_disp", 32'(disp_a), 0);

        // Second instance: PRESC=4, RAMP_PERIODS=2
        rst_a = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_disp", 32'(disp_b), 0);
        check("b_rst_running", 32'(run_b), 0);
        pulse_b(1'b1, 1'b0);
        check("b_target_10", 32'(disp_b), 10);
        wait_mb(200);
        pulse_b(1'b0, 1'b1);
        check("b_start", 32'(run_b), 2'b01);
        for (int k = 1; k <= 21; k++) begin
            window_b(c0, c1);
            check("b_ramp", c0, 4 * (((k / 2) > 10) ? 10 : (k / 2)));
        end

        pulse_b(1'b1, 1'b0);
        check("b_target_20", 32'(disp_b), 20);
        window_b(c0, c1);
        wait_mb(20);
        check("b_pre_rst_pwm", 32'(pwm_b), 2'b01);
        rst_b = 1'b1; inc_b = 1'b1; ss_b = 1'b1;
        @(negedge clk);
        check("b_rst_mid_pwm", 32'(pwm_b), 0);
        check("b_rst_mid_running", 32'(run_b), 0);
        check("b_rst_mid_disp", 32'(disp_b), 0);
        rst_b = 1'b0; inc_b = 1'b0; ss_b = 1'b0;
        @(negedge clk);
        check("b_rst_pulse_dropped", 32'(disp_b), 0);
        check("b_rst_state_idle", 32'(run_b), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
